// File: rtl/regfile_banked_if.sv
// Register file bus between the decoder/control FSM and the ALU/memory path.
// The master drives the selects, enables and write-back data. The slave
// returns the operands, PC/SP, the active bank and the sticky SP flags.
interface regfile_banked_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned BANK_W = 1
);
    logic [ADDR_W-1:0] src_sel;
    logic [ADDR_W-1:0] dst_sel;
    logic              wr_en;
    logic              wr_hi;
    logic              wr_lo;
    logic [DATA_W-1:0] wr_data;
    logic              pc_inc;
    logic              sp_inc;
    logic              sp_dec;
    logic [BANK_W-1:0] bank_sel;
    logic              bank_ld;
    logic              flag_clr;
    logic [DATA_W-1:0] src;
    logic [DATA_W-1:0] dst;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] sp;
    logic [BANK_W-1:0] cur_bank;
    logic              sp_ovf;
    logic              sp_unf;

    modport master (
        output src_sel, dst_sel, wr_en, wr_hi, wr_lo, wr_data,
               pc_inc, sp_inc, sp_dec, bank_sel, bank_ld, flag_clr,
        input  src, dst, pc, sp, cur_bank, sp_ovf, sp_unf
    );

    modport slave (
        input  src_sel, dst_sel, wr_en, wr_hi, wr_lo, wr_data,
               pc_inc, sp_inc, sp_dec, bank_sel, bank_ld, flag_clr,
        output src, dst, pc, sp, cur_bank, sp_ovf, sp_unf
    );
endinterface

// File: rtl/regfile_banked.sv
// Banked register file with a shared PC and SP.
// Index 0 reads as zero. The PC and SP indices are common to all banks.
// Every other index is banked by cur_bank. SP steps are bounded to
// [SP_LO, SP_HI]. A refused step sets a sticky overflow/underflow flag.
module regfile_banked #(
    parameter int unsigned          DATA_W    = 16,
    parameter int unsigned          ADDR_W    = 4,
    parameter int unsigned          NUM_BANKS = 2,
    parameter int unsigned          PC_IDX    = 1,
    parameter int unsigned          SP_IDX    = 2,
    parameter logic [DATA_W-1:0]    PC_RESET  = 'h00FF,
    parameter logic [DATA_W-1:0]    SP_RESET  = 'h0000,
    parameter logic [DATA_W-1:0]    SP_LO     = 'h0000,
    parameter logic [DATA_W-1:0]    SP_HI     = 'hFFFF
) (
    input  logic             clk,
    input  logic             rst,
    regfile_banked_if.slave  bus
);
    localparam int unsigned       NREGS  = 1 << ADDR_W;
    localparam int unsigned       BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam logic [ADDR_W-1:0] PC_SEL = ADDR_W'(PC_IDX);
    localparam logic [ADDR_W-1:0] SP_SEL = ADDR_W'(SP_IDX);

    logic [DATA_W-1:0] gpr_q [NUM_BANKS][NREGS];
    logic [DATA_W-1:0] gpr_d [NUM_BANKS][NREGS];
    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] sp_q, sp_d;
    logic [BANK_W-1:0] bank_q, bank_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    logic [DATA_W-1:0] src_val, dst_val, wr_val;
    logic              wr_any, wr_pc, wr_sp, wr_gpr;

    // Combinational source operand read. There is no write bypass.
    always_comb begin
        src_val = '0;
        if (bus.src_sel == PC_SEL)       src_val = pc_q;
        else if (bus.src_sel == SP_SEL)  src_val = sp_q;
        else if (bus.src_sel != '0)      src_val = gpr_q[bank_q][bus.src_sel];
    end

    // Combinational destination operand read. It is also the base for lane merges.
    always_comb begin
        dst_val = '0;
        if (bus.dst_sel == PC_SEL)       dst_val = pc_q;
        else if (bus.dst_sel == SP_SEL)  dst_val = sp_q;
        else if (bus.dst_sel != '0)      dst_val = gpr_q[bank_q][bus.dst_sel];
    end

    // Build the write-back word. A full write beats lane writes. Lanes only touch bits [15:0].
    always_comb begin
        wr_val = dst_val;
        if (bus.wr_en) begin
            wr_val = bus.wr_data;
        end else begin
            if (bus.wr_hi) wr_val[15:8] = bus.wr_data[7:0];
            if (bus.wr_lo) wr_val[7:0]  = bus.wr_data[7:0];
        end
        wr_any = (bus.wr_en || bus.wr_hi || bus.wr_lo) && (bus.dst_sel != '0);
        wr_pc  = wr_any && (bus.dst_sel == PC_SEL);
        wr_sp  = wr_any && (bus.dst_sel == SP_SEL);
        wr_gpr = wr_any && !wr_pc && !wr_sp;
    end

    // Banked general-register update. It uses the bank active before any bank_ld.
    always_comb begin
        gpr_d = gpr_q;
        if (wr_gpr) gpr_d[bank_q][bus.dst_sel] = wr_val;
    end

    // PC next state. An explicit write beats the auto-increment.
    always_comb begin
        pc_d = pc_q;
        if (wr_pc)           pc_d = wr_val;
        else if (bus.pc_inc) pc_d = pc_q + 1'b1;
    end

    // SP next state and flags. A refused step holds SP and sets its flag. A set beats flag_clr.
    always_comb begin
        sp_d  = sp_q;
        ovf_d = bus.flag_clr ? 1'b0 : ovf_q;
        unf_d = bus.flag_clr ? 1'b0 : unf_q;
        if (wr_sp) begin
            sp_d = wr_val;
        end else if (bus.sp_inc && !bus.sp_dec) begin
            if (sp_q == SP_HI) ovf_d = 1'b1;
            else               sp_d  = sp_q + 1'b1;
        end else if (bus.sp_dec && !bus.sp_inc) begin
            if (sp_q == SP_LO) unf_d = 1'b1;
            else               sp_d  = sp_q - 1'b1;
        end
    end

    // Bank select. An out-of-range request is ignored. A single-bank build stays at 0.
    always_comb begin
        bank_d = bank_q;
        if (NUM_BANKS == 1)
            bank_d = '0;
        else if (bus.bank_ld && (32'(bus.bank_sel) < NUM_BANKS))
            bank_d = bus.bank_sel;
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned b = 0; b < NUM_BANKS; b++)
                for (int unsigned r = 0; r < NREGS; r++)
                    gpr_q[b][r] <= '0;
            pc_q   <= PC_RESET;
            sp_q   <= SP_RESET;
            bank_q <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            gpr_q  <= gpr_d;
            pc_q   <= pc_d;
            sp_q   <= sp_d;
            bank_q <= bank_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
        end
    end

    assign bus.src      = src_val;
    assign bus.dst      = dst_val;
    assign bus.pc       = pc_q;
    assign bus.sp       = sp_q;
    assign bus.cur_bank = bank_q;
    assign bus.sp_ovf   = ovf_q;
    assign bus.sp_unf   = unf_q;
endmodule

// File: tb/tb_regfile_banked.sv
// Directed bench for regfile_banked.
// Instance A uses 16-bit registers, 2 banks and SP bounds 0x10..0x12.
// Instance B uses 32-bit registers, 32 registers and 3 banks.
module tb_regfile_banked;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    regfile_banked_if #(.DATA_W(16), .ADDR_W(4), .BANK_W(1)) ifa ();
    regfile_banked_if #(.DATA_W(32), .ADDR_W(5), .BANK_W(2)) ifb ();

    regfile_banked #(
        .DATA_W(16), .ADDR_W(4), .NUM_BANKS(2), .PC_IDX(1), .SP_IDX(2),
        .PC_RESET(16'h00FF), .SP_RESET(16'h0000), .SP_LO(16'h0010), .SP_HI(16'h0012)
    ) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));

    regfile_banked #(
        .DATA_W(32), .ADDR_W(5), .NUM_BANKS(3), .PC_IDX(1), .SP_IDX(2),
        .PC_RESET(32'h000000FF), .SP_RESET(32'h0), .SP_LO(32'h0), .SP_HI(32'h0000FFFF)
    ) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_a();
        ifa.src_sel = '0; ifa.dst_sel = '0; ifa.wr_en = 0; ifa.wr_hi = 0; ifa.wr_lo = 0;
        ifa.wr_data = '0; ifa.pc_inc = 0; ifa.sp_inc = 0; ifa.sp_dec = 0;
        ifa.bank_sel = '0; ifa.bank_ld = 0; ifa.flag_clr = 0;
    endtask

    task automatic idle_b();
        ifb.src_sel = '0; ifb.dst_sel = '0; ifb.wr_en = 0; ifb.wr_hi = 0; ifb.wr_lo = 0;
        ifb.wr_data = '0; ifb.pc_inc = 0; ifb.sp_inc = 0; ifb.sp_dec = 0;
        ifb.bank_sel = '0; ifb.bank_ld = 0; ifb.flag_clr = 0;
    endtask

    // One rising edge, then settle 1 time unit so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_a(); idle_b();
        rst = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++; if (ifa.pc !== 16'h00FF) begin errors++; $display("FAIL reset_pc got %h exp %h", ifa.pc, 16'h00FF); end
        checks++; if (ifa.sp !== 16'h0000) begin errors++; $display("FAIL reset_sp got %h exp %h", ifa.sp, 16'h0000); end
        ifa.src_sel = 4'd5; ifa.dst_sel = 4'd15; #1;
        checks++; if (ifa.src !== 16'h0000) begin errors++; $display("FAIL reset_src got %h exp 0000", ifa.src); end
        checks++; if (ifa.dst !== 16'h0000) begin errors++; $display("FAIL reset_dst got %h exp 0000", ifa.dst); end
        checks++; if (ifa.cur_bank !== 1'b0) begin errors++; $display("FAIL reset_bank got %h exp 0", ifa.cur_bank); end
        checks++; if ({ifa.sp_ovf, ifa.sp_unf} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b exp 00", {ifa.sp_ovf, ifa.sp_unf}); end
        checks++; if (ifb.pc !== 32'h000000FF) begin errors++; $display("FAIL reset_pc_b got %h exp 000000ff", ifb.pc); end
        tick();
        rst = 1'b0;
        idle_a();
        tick();
    endtask

    task automatic test_write_lanes();
        idle_a();
        ifa.dst_sel = 4'd5; ifa.wr_en = 1; ifa.wr_data = 16'h1234; #1;
        checks++; if (ifa.dst !== 16'h0000) begin errors++; $display("FAIL no_bypass got %h exp 0000", ifa.dst); end
        tick(); ifa.wr_en = 0; #1;
        checks++; if (ifa.dst !== 16'h1234) begin errors++; $display("FAIL wr_full got %h exp 1234", ifa.dst); end
        ifa.wr_hi = 1; ifa.wr_data = 16'h00AB; tick(); ifa.wr_hi = 0; #1;
        checks++; if (ifa.dst !== 16'hAB34) begin errors++; $display("FAIL wr_hi got %h exp ab34", ifa.dst); end
        ifa.wr_lo = 1; ifa.wr_data = 16'h00CD; tick(); ifa.wr_lo = 0; #1;
        checks++; if (ifa.dst !== 16'hABCD) begin errors++; $display("FAIL wr_lo got %h exp abcd", ifa.dst); end
        ifa.wr_hi = 1; ifa.wr_lo = 1; ifa.wr_data = 16'hFF77; tick(); ifa.wr_hi = 0; ifa.wr_lo = 0; #1;
        checks++; if (ifa.dst !== 16'h7777) begin errors++; $display("FAIL wr_both got %h exp 7777", ifa.dst); end
        ifa.wr_en = 1; ifa.wr_hi = 1; ifa.wr_data = 16'h5A5A; tick(); ifa.wr_en = 0; ifa.wr_hi = 0; #1;
        checks++; if (ifa.dst !== 16'h5A5A) begin errors++; $display("FAIL wr_en_prio got %h exp 5a5a", ifa.dst); end
        ifa.dst_sel = 4'd0; ifa.wr_en = 1; ifa.wr_data = 16'hFFFF; tick();
        ifa.wr_en = 0; ifa.wr_hi = 1; ifa.wr_lo = 1; tick(); ifa.wr_hi = 0; ifa.wr_lo = 0;
        ifa.src_sel = 4'd0; #1;
        checks++; if (ifa.src !== 16'h0000) begin errors++; $display("FAIL r0_zero got %h exp 0000", ifa.src); end
        idle_a();
    endtask

    task automatic test_pc();
        idle_a();
        ifa.dst_sel = 4'd1; ifa.wr_en = 1; ifa.wr_data = 16'hFFFF; tick(); ifa.wr_en = 0; #1;
        checks++; if (ifa.pc !== 16'hFFFF) begin errors++; $display("FAIL pc_write got %h exp ffff", ifa.pc); end
        ifa.pc_inc = 1; tick(); ifa.pc_inc = 0; #1;
        checks++; if (ifa.pc !== 16'h0000) begin errors++; $display("FAIL pc_wrap got %h exp 0000", ifa.pc); end
        ifa.pc_inc = 1; ifa.wr_en = 1; ifa.wr_data = 16'h0200; tick(); ifa.wr_en = 0; ifa.pc_inc = 0; #1;
        checks++; if (ifa.pc !== 16'h0200) begin errors++; $display("FAIL pc_wr_prio got %h exp 0200", ifa.pc); end
        ifa.pc_inc = 1; tick(); ifa.pc_inc = 0; #1;
        checks++; if (ifa.pc !== 16'h0201) begin errors++; $display("FAIL pc_inc got %h exp 0201", ifa.pc); end
        ifa.pc_inc = 1; ifa.wr_lo = 1; ifa.wr_data = 16'h0033; tick(); ifa.pc_inc = 0; ifa.wr_lo = 0;
        ifa.src_sel = 4'd1; #1;
        checks++; if (ifa.src !== 16'h0233) begin errors++; $display("FAIL pc_lane_prio got %h exp 0233", ifa.src); end
        idle_a();
    endtask

    task automatic test_sp_bounds();
        idle_a();
        ifa.dst_sel = 4'd2; ifa.wr_en = 1; ifa.wr_data = 16'h0012; ifa.sp_dec = 1; tick();
        ifa.wr_en = 0; ifa.sp_dec = 0; #1;
        checks++; if (ifa.sp !== 16'h0012) begin errors++; $display("FAIL sp_wr_prio got %h exp 0012", ifa.sp); end
        ifa.sp_inc = 1; tick(); ifa.sp_inc = 0; #1;
        checks++; if (ifa.sp !== 16'h0012) begin errors++; $display("FAIL sp_hi_hold got %h exp 0012", ifa.sp); end
        checks++; if ({ifa.sp_ovf, ifa.sp_unf} !== 2'b10) begin errors++; $display("FAIL sp_ovf_set got %b exp 10", {ifa.sp_ovf, ifa.sp_unf}); end
        ifa.sp_dec = 1; tick(); #1;
        checks++; if (ifa.sp !== 16'h0011) begin errors++; $display("FAIL sp_dec1 got %h exp 0011", ifa.sp); end
        tick(); #1;
        checks++; if (ifa.sp !== 16'h0010) begin errors++; $display("FAIL sp_dec2 got %h exp 0010", ifa.sp); end
        tick(); ifa.sp_dec = 0; #1;
        checks++; if (ifa.sp !== 16'h0010) begin errors++; $display("FAIL sp_lo_hold got %h exp 0010", ifa.sp); end
        checks++; if ({ifa.sp_ovf, ifa.sp_unf} !== 2'b11) begin errors++; $display("FAIL sp_unf_set got %b exp 11", {ifa.sp_ovf, ifa.sp_unf}); end
        ifa.sp_inc = 1; ifa.sp_dec = 1; ifa.flag_clr = 1; tick(); ifa.sp_inc = 0; ifa.sp_dec = 0; ifa.flag_clr = 0; #1;
        checks++; if (ifa.sp !== 16'h0010) begin errors++; $display("FAIL sp_inc_dec got %h exp 0010", ifa.sp); end
        checks++; if ({ifa.sp_ovf, ifa.sp_unf} !== 2'b00) begin errors++; $display("FAIL flag_clr got %b exp 00", {ifa.sp_ovf, ifa.sp_unf}); end
        ifa.sp_dec = 1; ifa.flag_clr = 1; tick(); ifa.sp_dec = 0; ifa.flag_clr = 0; #1;
        checks++; if ({ifa.sp_ovf, ifa.sp_unf} !== 2'b01) begin errors++; $display("FAIL set_beats_clr got %b exp 01", {ifa.sp_ovf, ifa.sp_unf}); end
        ifa.flag_clr = 1; tick(); ifa.flag_clr = 0;
        ifa.sp_inc = 1; tick(); ifa.sp_inc = 0; #1;
        checks++; if (ifa.sp !== 16'h0011) begin errors++; $display("FAIL sp_inc got %h exp 0011", ifa.sp); end
        checks++; if ({ifa.sp_ovf, ifa.sp_unf} !== 2'b00) begin errors++; $display("FAIL flags_clean got %b exp 00", {ifa.sp_ovf, ifa.sp_unf}); end
        idle_a();
    endtask

    task automatic test_banking();
        idle_a();
        ifa.dst_sel = 4'd5; ifa.wr_en = 1; ifa.wr_data = 16'h1111; tick();
        ifa.wr_data = 16'h2222; ifa.bank_ld = 1; ifa.bank_sel = 1'b1; #1;
        checks++; if (ifa.dst !== 16'h1111) begin errors++; $display("FAIL bank_old_read got %h exp 1111", ifa.dst); end
        tick(); ifa.wr_en = 0; ifa.bank_ld = 0; #1;
        checks++; if (ifa.cur_bank !== 1'b1) begin errors++; $display("FAIL bank_switch got %h exp 1", ifa.cur_bank); end
        checks++; if (ifa.dst !== 16'h0000) begin errors++; $display("FAIL bank1_r5 got %h exp 0000", ifa.dst); end
        checks++; if (ifa.pc !== 16'h0233) begin errors++; $display("FAIL bank_pc_shared got %h exp 0233", ifa.pc); end
        checks++; if (ifa.sp !== 16'h0011) begin errors++; $display("FAIL bank_sp_shared got %h exp 0011", ifa.sp); end
        ifa.wr_en = 1; ifa.wr_data = 16'h3333; tick(); ifa.wr_en = 0;
        ifa.bank_ld = 1; ifa.bank_sel = 1'b0; tick(); ifa.bank_ld = 0; #1;
        checks++; if (ifa.dst !== 16'h2222) begin errors++; $display("FAIL bank0_r5 got %h exp 2222", ifa.dst); end
        ifa.bank_ld = 1; ifa.bank_sel = 1'b1; tick(); ifa.bank_ld = 0; #1;
        checks++; if (ifa.dst !== 16'h3333) begin errors++; $display("FAIL bank1_r5_kept got %h exp 3333", ifa.dst); end
        idle_a();
    endtask

    task automatic test_wide();
        idle_b();
        ifb.dst_sel = 5'd31; ifb.wr_en = 1; ifb.wr_data = 32'hDEADBEEF; tick(); ifb.wr_en = 0; #1;
        checks++; if (ifb.dst !== 32'hDEADBEEF) begin errors++; $display("FAIL w_r31 got %h exp deadbeef", ifb.dst); end
        ifb.wr_hi = 1; ifb.wr_data = 32'h111111AB; tick(); ifb.wr_hi = 0; #1;
        checks++; if (ifb.dst !== 32'hDEADABEF) begin errors++; $display("FAIL w_hi got %h exp deadabef", ifb.dst); end
        ifb.wr_lo = 1; ifb.wr_data = 32'h22222212; tick(); ifb.wr_lo = 0; #1;
        checks++; if (ifb.dst !== 32'hDEADAB12) begin errors++; $display("FAIL w_lo got %h exp deadab12", ifb.dst); end
        ifb.dst_sel = 5'd1; ifb.wr_en = 1; ifb.wr_data = 32'hFFFFFFFF; tick(); ifb.wr_en = 0;
        ifb.pc_inc = 1; tick(); ifb.pc_inc = 0; #1;
        checks++; if (ifb.pc !== 32'h00000000) begin errors++; $display("FAIL w_pc_wrap got %h exp 00000000", ifb.pc); end
        ifb.dst_sel = 5'd31; ifb.bank_ld = 1; ifb.bank_sel = 2'd2; tick(); ifb.bank_ld = 0; #1;
        checks++; if (ifb.cur_bank !== 2'd2) begin errors++; $display("FAIL w_bank2 got %h exp 2", ifb.cur_bank); end
        checks++; if (ifb.dst !== 32'h0) begin errors++; $display("FAIL w_bank2_r31 got %h exp 00000000", ifb.dst); end
        ifb.bank_ld = 1; ifb.bank_sel = 2'd3; tick(); ifb.bank_ld = 0; #1;
        checks++; if (ifb.cur_bank !== 2'd2) begin errors++; $display("FAIL w_bank_oor got %h exp 2", ifb.cur_bank); end
        ifb.bank_ld = 1; ifb.bank_sel = 2'd0; tick(); ifb.bank_ld = 0; #1;
        checks++; if (ifb.dst !== 32'hDEADAB12) begin errors++; $display("FAIL w_bank0_r31 got %h exp deadab12", ifb.dst); end
        idle_b();
    endtask

    task automatic test_reset_midop();
        idle_a();
        ifa.dst_sel = 4'd5; ifa.wr_en = 1; ifa.wr_data = 16'h9999;
        ifa.pc_inc = 1; ifa.sp_inc = 1; ifa.bank_ld = 1; ifa.bank_sel = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++; if (ifa.pc !== 16'h00FF) begin errors++; $display("FAIL mid_rst_pc got %h exp 00ff", ifa.pc); end
        checks++; if (ifa.cur_bank !== 1'b0) begin errors++; $display("FAIL mid_rst_bank got %h exp 0", ifa.cur_bank); end
        tick();
        rst = 1'b0;
        idle_a();
        ifa.dst_sel = 4'd5; ifa.src_sel = 4'd2; #1;
        checks++; if (ifa.dst !== 16'h0000) begin errors++; $display("FAIL mid_rst_r5 got %h exp 0000", ifa.dst); end
        checks++; if (ifa.src !== 16'h0000) begin errors++; $display("FAIL mid_rst_sp got %h exp 0000", ifa.src); end
        tick();
        checks++; if (ifa.pc !== 16'h00FF) begin errors++; $display("FAIL post_rst_pc got %h exp 00ff", ifa.pc); end
        idle_a();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        test_reset();
        test_write_lanes();
        test_pc();
        test_sp_bounds();
        test_banking();
        test_wide();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
